// File: rtl/closest_hit_select.sv
// Closest-hit selector: captures one ray, scans its candidate intersections and
// emits the nearest qualified hit (non-negative finite non-zero t) with its index.
module closest_hit_select #(
   parameter int unsigned SIZE = 32
) (
   input  logic                aclk,
   input  logic                areset,

   input  logic [6*SIZE-1:0]   ray_axis_tdata,
   input  logic                ray_axis_tvalid,
   output logic                ray_axis_tready,

   input  logic [SIZE-1:0]     cand_axis_t,
   input  logic                cand_axis_hit,
   input  logic [6*SIZE-1:0]   cand_axis_obj,
   input  logic                cand_axis_is_cylinder,
   input  logic                cand_axis_tlast,
   input  logic                cand_axis_tvalid,
   output logic                cand_axis_tready,

   output logic [6*SIZE-1:0]   out_ray,
   output logic [6*SIZE-1:0]   out_obj,
   output logic                out_is_cylinder,
   output logic [SIZE-1:0]     out_t,
   output logic                out_any_hit,
   output logic [7:0]          out_best_idx,
   output logic                out_tvalid,
   input  logic                out_tready
);

   localparam int unsigned ExpW = (SIZE == 64) ? 11 : (SIZE == 16) ? 5 : 8;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StAccum = 2'd1;
   localparam logic [1:0] StEmit  = 2'd2;

   logic [1:0]          state_q,      state_d;
   logic [6*SIZE-1:0]   ray_q,        ray_d;
   logic                best_valid_q, best_valid_d;
   logic [SIZE-1:0]     best_t_q,     best_t_d;
   logic [6*SIZE-1:0]   best_obj_q,   best_obj_d;
   logic                best_cyl_q,   best_cyl_d;
   logic [7:0]          best_idx_q,   best_idx_d;
   logic [7:0]          idx_q,        idx_d;

   logic [ExpW-1:0]     cand_exp;
   logic                cand_qual;
   logic                cand_take;

   // Non-negative IEEE floats order the same as their unsigned bit patterns.
   always_comb begin
      cand_exp  = cand_axis_t[SIZE-2 -: ExpW];
      cand_qual = cand_axis_hit & ~cand_axis_t[SIZE-1] & ~(&cand_exp) & (|cand_axis_t);
      cand_take = cand_qual & (~best_valid_q | (cand_axis_t < best_t_q));
   end

   always_comb begin
      ray_axis_tready  = (state_q == StIdle);
      cand_axis_tready = (state_q == StAccum);
      out_tvalid       = (state_q == StEmit);
      out_ray          = ray_q;
      out_obj          = best_obj_q;
      out_is_cylinder  = best_cyl_q;
      out_t            = best_t_q;
      out_any_hit      = best_valid_q;
      out_best_idx     = best_idx_q;
   end

   always_comb begin
      state_d      = state_q;
      ray_d        = ray_q;
      best_valid_d = best_valid_q;
      best_t_d     = best_t_q;
      best_obj_d   = best_obj_q;
      best_cyl_d   = best_cyl_q;
      best_idx_d   = best_idx_q;
      idx_d        = idx_q;
      case (state_q)
         StIdle: begin
            if (ray_axis_tvalid) begin
               ray_d        = ray_axis_tdata;
               best_valid_d = 1'b0;
               best_t_d     = '0;
               best_obj_d   = '0;
               best_cyl_d   = 1'b0;
               best_idx_d   = '0;
               idx_d        = '0;
               state_d      = StAccum;
            end
         end
         StAccum: begin
            if (cand_axis_tvalid) begin
               if (cand_take) begin
                  best_valid_d = 1'b1;
                  best_t_d     = cand_axis_t;
                  best_obj_d   = cand_axis_obj;
                  best_cyl_d   = cand_axis_is_cylinder;
                  best_idx_d   = idx_q;
               end
               // Saturate so every beat past index 255 reports 255.
               if (idx_q != 8'd255) begin
                  idx_d = idx_q + 8'd1;
               end
               if (cand_axis_tlast) begin
                  state_d = StEmit;
               end
            end
         end
         StEmit: begin
            if (out_tready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= StIdle;
         ray_q        <= '0;
         best_valid_q <= 1'b0;
         best_t_q     <= '0;
         best_obj_q   <= '0;
         best_cyl_q   <= 1'b0;
         best_idx_q   <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         ray_q        <= ray_d;
         best_valid_q <= best_valid_d;
         best_t_q     <= best_t_d;
         best_obj_q   <= best_obj_d;
         best_cyl_q   <= best_cyl_d;
         best_idx_q   <= best_idx_d;
         idx_q        <= idx_d;
      end
   end

endmodule

// File: doc/closest_hit_select.md
CLOSEST_HIT_SELECT -- requirements
Module: closest_hit_select

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning the float word width (IEEE-754 single precision).
REQ-002 SHALL have port aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ray_axis_tdata, input, 6xSIZE: ray direction [5:3] and origin [2:0].
REQ-005 SHALL have ports ray_axis_tvalid (input, 1 bit) and ray_axis_tready (output, 1 bit): the ray handshake.
REQ-006 SHALL have port cand_axis_t, input, SIZE: intersection distance t of the candidate object.
REQ-007 SHALL have port cand_axis_hit, input, 1 bit: the candidate intersects the ray.
REQ-008 SHALL have port cand_axis_obj, input, 6xSIZE: object center [2:0] and axis [5:3].
REQ-009 SHALL have ports cand_axis_is_cylinder (input, 1 bit) and cand_axis_tlast (input, 1 bit): object-type flag and last-candidate-of-ray marker.
REQ-010 SHALL have ports cand_axis_tvalid (input, 1 bit) and cand_axis_tready (output, 1 bit): the candidate handshake.
REQ-011 SHALL have port out_ray, output, 6xSIZE: the captured ray.
REQ-012 SHALL have ports out_obj (output, 6xSIZE), out_is_cylinder (output, 1 bit) and out_t (output, SIZE): data of the winning candidate.
REQ-013 SHALL have ports out_any_hit (output, 1 bit) and out_best_idx (output, 8 bits): at least one valid hit, and the index of the winner within its ray.
REQ-014 SHALL have ports out_tvalid (output, 1 bit) and out_tready (input, 1 bit): a single handshake covering all out_* signals.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and EMIT; reset state is IDLE.
REQ-016 SHALL, in IDLE, drive ray_axis_tready=1 and cand_axis_tready=0; a ray handshake captures ray_axis_tdata, clears best-state (no best, idx counter=0) and moves to ACCUM.
REQ-017 SHALL, in ACCUM, drive cand_axis_tready=1 and ray_axis_tready=0; each accepted beat is evaluated in the cycle it is accepted.
REQ-018 SHALL treat a beat as qualified iff cand_axis_hit=1, sign bit=0, exponent not all-ones (no NaN/Inf) and t != +0.
REQ-019 SHALL compare qualified t values as unsigned SIZE-bit integers (valid for non-negative floats); no float IP is used.
REQ-020 SHALL replace the best (t, obj, is_cylinder, idx) when a qualified beat arrives with no best held, or with t strictly less than best t; on a tie the earlier candidate is kept.
REQ-021 SHALL keep an 8-bit candidate index counter incremented per accepted beat and saturating at 255; beats beyond index 255 report idx 255.
REQ-022 SHALL move to EMIT on an accepted beat with tlast=1, with that beat included in the selection; out_tvalid=1 on the next cycle (1-cycle latency from tlast).
REQ-023 SHALL, in EMIT, hold every out_* signal stable while out_tvalid=1 and out_tready=0; on handshake return to IDLE; cand_axis_tready=0 and ray_axis_tready=0 in EMIT.
REQ-024 SHALL, when no qualified beat occurred, emit out_any_hit=0 with out_t, out_obj, out_is_cylinder and out_best_idx all 0; out_ray is still valid.
REQ-025 SHALL drive out_any_hit=1 and the winner's fields when at least one qualified beat occurred.
REQ-026 SHALL ignore cand_axis_* outside ACCUM, since tready=0 there.
REQ-027 SHALL accept a single-beat ray (tlast on first candidate) and process it identically.
REQ-028 SHALL give a maximum throughput of one ray per (N candidates + 2) cycles.

Reset
REQ-029 SHALL, on areset asserted at any time (including mid-ACCUM or mid-EMIT), immediately force IDLE, clear out_tvalid, all out_* data and the best-state registers to 0, and discard any partial ray.
REQ-030 SHALL have no output handshake complete during reset; after deassertion the first cycle presents ray_axis_tready=1.

Verification
REQ-031 SHALL cover: ray R, candidates t={5.0,2.0,3.0} all hit, tlast on third -> out_t=0x40000000, out_best_idx=1, out_any_hit=1, out_tvalid one cycle after the third beat.
REQ-032 SHALL cover: candidates t={2.0 hit, 2.0 hit, 1.0 hit=0} -> out_best_idx=0, out_t=0x40000000 (tie kept, non-hit ignored).
REQ-033 SHALL cover: candidates {-1.0 hit, NaN 0x7FC00000 hit, 0.0 hit} -> out_any_hit=0, out_t=0, out_obj=0, out_ray=R.
REQ-034 SHALL cover: out_tready held 0 for 10 cycles in EMIT -> out_* stable, cand_axis_tready=0 and ray_axis_tready=0 throughout; release -> IDLE next cycle.
REQ-035 SHALL cover: areset pulsed after 2 of 4 candidates -> out_tvalid=0 and outputs 0; a new ray with t={4.0} afterward -> out_t=0x40800000, idx 0.
REQ-036 SHALL cover: 300 candidates with minimum t=0.5 at index 280 -> out_t=0x3F000000, out_best_idx=255.
